data_memory_lsu: RTL
====================

// Module: data_memory_lsu
// PURPOSE
//  Byte-addressed data memory with byte/half/word loads and stores. Loads are
//  sign- or zero-extended. Each request gets an error response for misaligned
//  or out-of-range accesses. Request/response valid-ready handshake with a
//  registered 1-cycle read latency. Sits in the datapath MEM stage; it is the
//  parametrised successor of the fixed 256x32 asynchronous-read data memory.
// PARAMETERS
//  DEPTH_WORDS  256  number of 32-bit words; power of two, >=4
//  ADDR_W       32   width of the byte address input
//  AW           $clog2(DEPTH_WORDS)  derived word-index width (localparam)
// PORTS
//  clk          in   1       clock, all state on posedge
//  rst_n        in   1       asynchronous active-low reset
//  req_valid    in   1       request present
//  req_ready    out  1       block can accept a request this cycle
//  req_write    in   1       1=store, 0=load
//  req_size     in   2       00=byte, 01=half, 10=word, 11=illegal (error)
//  req_unsigned in   1       loads: 1=zero-extend, 0=sign-extend
//  address      in   ADDR_W  byte address
//  write_data   in   32      store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid    out  1       response present
//  rsp_ready    in   1       consumer takes the response
//  read_data    out  32      extended load data; 0 for stores and errors
//  rsp_err      out  1       1=misaligned, out-of-range or illegal size
// BEHAVIOUR
//  - Reset (rst_n low, async): rsp_valid=0, read_data=0, rsp_err=0,
//    req_ready=0. Memory contents are not reset.
//  - Handshake: accept = req_valid & req_ready.
//    req_ready = ~rst_n_active & ~clearing & (~rsp_valid | rsp_ready).
//    This is a one-entry output register with full-throughput pass-through.
//  - Latency: accept at edge N sets rsp_valid after edge N. The response
//    holds stable until rsp_valid & rsp_ready. Stores also respond.
//  - Decode: word = address[AW+1:2], lane = address[1:0].
//    Error if req_size==11, or if half & lane[0], or if word & lane!=0.
//    Error also if address >= 4*DEPTH_WORDS. No address wrap-around.
//  - Error request: no memory write; response has read_data=0, rsp_err=1.
//  - Store, byte-enabled, written at the accept edge:
//    byte -> write_data[7:0] into lane. Half -> write_data[15:0] into bytes
//    lane..lane+1. Word -> all 4 bytes. Unaddressed bytes are preserved.
//  - Load: word read at the accept edge. Selected byte/half is shifted down
//    and extended per req_unsigned. Word is returned unmodified.
//  - Load immediately after a store to the same word, in the next accepted
//    cycle, returns the new data. Only one request per cycle, so there is no
//    same-cycle hazard.
//  - rsp_valid & rsp_ready & req_valid in one cycle: the old response retires
//    and the new one loads at the same edge. Back-to-back at 1 req/clk.
//  - rsp_valid & ~rsp_ready: req_ready=0 and no memory access occurs.
//  - Reset mid-operation: the in-flight response is dropped, and any store
//    accepted before reset has already completed.
// CONFIGURATION
//  DMEM_CLEAR_EN defined:
//  - FSM CLEAR->IDLE. On rst_n release, the state is CLEAR. The clear counter
//    writes 0 to word 0..DEPTH_WORDS-1, one word per clk.
//  - req_ready=0 throughout CLEAR. Enter IDLE after the last word.
//  - After reset it takes exactly DEPTH_WORDS cycles until req_ready=1.
//    Async reset during CLEAR restarts the sweep at word 0.
//  DMEM_CLEAR_EN undefined:
//  - No FSM. req_ready=1 on the first clk after rst_n release.
//    Memory powers up X.
// TESTING
//  1 Store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_valid next clk,
//    read_data=0xDEADBEEF, rsp_err=0.
//  2 Store byte 0x80 @0x11, then load byte signed @0x11 -> 0xFFFFFF80.
//    Unsigned -> 0x00000080. Load word @0x10 -> 0xDEAD80EF.
//  3 Load half @0x13 -> rsp_err=1, read_data=0. Store word @0x402 with
//    DEPTH_WORDS=256 -> rsp_err=1 and memory unchanged (verify by readback).
//  4 Hold rsp_ready=0 for 3 clk with req_valid=1 -> req_ready=0 and the
//    response stays stable. Then rsp_ready=1 and 4 back-to-back loads ->
//    4 responses on consecutive clks in order.
//  5 Assert rst_n=0 while rsp_valid=1 -> rsp_valid/read_data/rsp_err=0
//    immediately, without waiting for clk.
//  6 DMEM_CLEAR_EN: release reset -> req_ready=0 for 256 clk, then load @0x3FC
//    returns 0. Pulse reset at cycle 100 -> the count restarts at 256.

Source files
------------

// File: rtl/data_memory_lsu.sv
// Byte-addressed data memory with byte/half/word load-store, error responses and a one-entry response register.
// Optional DMEM_CLEAR_EN: zero the whole array after every reset before accepting requests.
module data_memory_lsu #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       read_data,
    output logic              rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]       mem [DEPTH_WORDS];
    logic              ready_en;
    logic              clearing;
    logic              accept;
    logic [AW-1:0]     word;
    logic [1:0]        lane;
    logic [ADDR_W-1:0] addr_hi;
    logic              err;
    logic [3:0]        be;
    logic [31:0]       wd_rep;
    logic [31:0]       rd_word;
    logic [15:0]       rd_half;
    logic [7:0]        rd_byte;
    logic [31:0]       ld_data;
    logic              mem_we;
    logic [AW-1:0]     mem_idx;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wd;

`ifdef DMEM_CLEAR_EN
    // state | meaning
    // CLEAR | sweeping zeros into word clr_idx, requests blocked
    // IDLE  | normal operation
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t        state;
    logic [AW-1:0] clr_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else if (state == CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == AW'(DEPTH_WORDS - 1))
                state <= IDLE;
        end
    end

    assign clearing = (state == CLEAR);
    assign ready_en = (state == IDLE);
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    assign clearing = 1'b0;
`endif

    assign req_ready = ready_en & ~clearing & (~rsp_valid | rsp_ready);
    assign accept    = req_valid & req_ready;

    assign word    = address[AW+1:2];
    assign lane    = address[1:0];
    assign addr_hi = address >> (AW + 2);
    assign err     = (req_size == 2'b11) |
                     ((req_size == 2'b01) & lane[0]) |
                     ((req_size == 2'b10) & (lane != 2'b00)) |
                     (|addr_hi);

    always_comb begin
        be     = 4'hF;
        wd_rep = write_data;
        case (req_size)
            2'b00: begin
                be     = 4'b0001 << lane;
                wd_rep = {4{write_data[7:0]}};
            end
            2'b01: begin
                be     = 4'b0011 << lane;
                wd_rep = {2{write_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign rd_word = mem[word];
    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    assign rd_byte = lane[0] ? rd_half[15:8]  : rd_half[7:0];

    always_comb begin
        case (req_size)
            2'b00:   ld_data = {{24{rd_byte[7]  & ~req_unsigned}}, rd_byte};
            2'b01:   ld_data = {{16{rd_half[15] & ~req_unsigned}}, rd_half};
            default: ld_data = rd_word;
        endcase
    end

    always_comb begin
        mem_we  = accept & req_write & ~err;
        mem_idx = word;
        mem_be  = be;
        mem_wd  = wd_rep;
`ifdef DMEM_CLEAR_EN
        if (clearing) begin
            mem_we  = 1'b1;
            mem_idx = clr_idx;
            mem_be  = 4'hF;
            mem_wd  = '0;
        end
`endif
    end

    // Array has no reset: contents survive rst_n unless the clear sweep runs.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_idx][b*8 +: 8] <= mem_wd[b*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            read_data <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            read_data <= (req_write | err) ? 32'h0 : ld_data;
            rsp_err   <= err;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
